// File: rtl/student_fir_pkg.sv
// Shared types and helpers for the FIR slice collector: FSM state encoding,
// accumulator sizing and the output limiter used when saturation is enabled.
package student_fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUM   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } collector_state_t;

  // Room for NUM_FIR full-width lanes plus one bit so rounding cannot overflow.
  function automatic int acc_width(input int data_size, input int num_fir);
    return 2 * data_size + $clog2(num_fir) + 1;
  endfunction

  function automatic logic signed [63:0] sat_limit(input logic signed [63:0] value,
                                                   input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/student_edge_detect.sv
// 1-bit rising-edge detector; rise is high for the cycle in which level
// goes 0 -> 1 relative to the previous clock.
module student_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= level;
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/student_fir_collector.sv
// Collects NUM_FIR FIR slice results, sums them one lane per cycle, rounds and
// scales to one output sample. Define STUDENT_FIR_COLLECTOR_SAT_EN to clamp
// instead of wrap when the scaled sum exceeds the DATA_SIZE range.
module student_fir_collector
  import student_fir_pkg::*;
#(
  parameter int NUM_FIR   = 4,
  parameter int DATA_SIZE = 16,
  parameter int OUT_SHIFT = 15
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_FIR-1:0]             fir_valid_i,
  input  logic [NUM_FIR*DATA_SIZE*2-1:0] fir_y_i,
  output logic [DATA_SIZE-1:0]           sample_o,
  output logic                           valid_strobe_o,
  output logic                           busy_o,
  output logic                           overrun_o
);

  localparam int LANE_W   = 2 * DATA_SIZE;
  localparam int ACC_W    = acc_width(DATA_SIZE, NUM_FIR);
  localparam int IDX_W    = (NUM_FIR > 1) ? $clog2(NUM_FIR) : 1;
  localparam int RND_SH   = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] ROUND_C =
    (OUT_SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_SH) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIR - 1);

  collector_state_t         state_q, state_d;
  logic [IDX_W-1:0]         idx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [NUM_FIR-1:0]       pending_q;
  logic [NUM_FIR-1:0]       rise;
  logic [LANE_W-1:0]        capture_q [NUM_FIR];
  logic signed [ACC_W:0]    rounded;
  logic [DATA_SIZE-1:0]     limited;

  for (genvar k = 0; k < NUM_FIR; k++) begin : g_edge
    student_edge_detect u_edge (
      .clk   (clk_i),
      .rst   (rst_i),
      .level (fir_valid_i[k]),
      .rise  (rise[k])
    );
  end

  // One extra bit so adding the half-LSB rounding constant never wraps.
  assign rounded = $signed({acc_q[ACC_W-1], acc_q}) + ROUND_C;

`ifdef STUDENT_FIR_COLLECTOR_SAT_EN
  assign limited = DATA_SIZE'(sat_limit(64'(rounded >>> OUT_SHIFT), DATA_SIZE));
`else
  assign limited = DATA_SIZE'(rounded >>> OUT_SHIFT);
`endif

  // NOTE: every output and next-state variable gets a default before the case,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    busy_o         = 1'b0;
    valid_strobe_o = 1'b0;
    unique case (state_q)
      IDLE:  if (&pending_q) state_d = SUM;
      SUM: begin
        busy_o = 1'b1;
        if (idx_q == LAST_IDX) state_d = ROUND;
      end
      ROUND: begin
        busy_o  = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        busy_o         = 1'b1;
        valid_strobe_o = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      pending_q <= '0;
      sample_o  <= '0;
      overrun_o <= 1'b0;
      // NOTE: the capture bank is small and must come up cleared, so it is
      // reset like ordinary flops rather than treated as a RAM.
      for (int k = 0; k < NUM_FIR; k++) capture_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      overrun_o <= |(rise & pending_q);

      // A lane still waiting to be summed keeps its first value.
      for (int k = 0; k < NUM_FIR; k++) begin
        if (rise[k] && !pending_q[k]) begin
          capture_q[k] <= fir_y_i[k*LANE_W +: LANE_W];
          pending_q[k] <= 1'b1;
        end else if (state_q == SUM && idx_q == IDX_W'(k)) begin
          pending_q[k] <= 1'b0;
        end
      end

      unique case (state_q)
        IDLE: begin
          acc_q <= '0;
          idx_q <= '0;
        end
        SUM: begin
          acc_q <= acc_q + ACC_W'($signed(capture_q[idx_q]));
          idx_q <= idx_q + 1'b1;
        end
        ROUND:   sample_o <= limited;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_student_fir_collector.sv
// Directed, table-driven bench for student_fir_collector (NUM_FIR=4,
// DATA_SIZE=16, OUT_SHIFT=15); honours STUDENT_FIR_COLLECTOR_SAT_EN.
module tb_student_fir_collector;

  localparam int NF  = 4;
  localparam int DS  = 16;
  localparam int LW  = 2 * DS;
  localparam int NEV = -1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NF-1:0]     fir_valid;
  logic [NF*LW-1:0]  fir_y;
  logic [DS-1:0]     sample;
  logic              valid_strobe;
  logic              busy;
  logic              overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string             name;
    logic [NF-1:0][LW-1:0] y;
    int                ec [NF];
    logic [DS-1:0]     exp_sample;
    int                exp_strobe;
  } vec_t;

  typedef struct {
    int            strobe_count;
    int            strobe_cycle;
    logic [DS-1:0] strobe_sample;
    int            busy_count;
    int            busy_first;
    int            ovr_count;
    int            ovr_cycle;
  } obs_t;

  student_fir_collector #(.NUM_FIR(NF), .DATA_SIZE(DS), .OUT_SHIFT(15)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fir_valid_i    (fir_valid),
    .fir_y_i        (fir_y),
    .sample_o       (sample),
    .valid_strobe_o (valid_strobe),
    .busy_o         (busy),
    .overrun_o      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Cycle c starts 1 time unit after a rising edge; outputs sampled mid-cycle.
  task automatic run_set(input logic [NF-1:0][LW-1:0] y, input int ec [NF],
                         input int cycles, output obs_t o);
    o = '{strobe_count: 0, strobe_cycle: -1, strobe_sample: '0,
          busy_count: 0, busy_first: -1, ovr_count: 0, ovr_cycle: -1};
    for (int c = 0; c < cycles; c++) begin
      for (int k = 0; k < NF; k++) begin
        fir_valid[k] = (ec[k] == c);
        if (ec[k] == c) fir_y[k*LW +: LW] = y[k];
      end
      @(negedge clk);
      if (valid_strobe) begin
        if (o.strobe_count == 0) begin
          o.strobe_cycle  = c;
          o.strobe_sample = sample;
        end
        o.strobe_count++;
      end
      if (busy) begin
        if (o.busy_count == 0) o.busy_first = c;
        o.busy_count++;
      end
      if (overrun) begin
        o.ovr_cycle = c;
        o.ovr_count++;
      end
      @(posedge clk);
      #1;
    end
    fir_valid = '0;
  endtask

  task automatic check_set(input string name, input obs_t o,
                           input logic [DS-1:0] exp_sample, input int exp_strobe);
    check({name, " strobe_count"}, 64'(o.strobe_count), 64'd1);
    check({name, " strobe_cycle"}, 64'(o.strobe_cycle), 64'(exp_strobe));
    check({name, " sample"},       64'(o.strobe_sample), 64'(exp_sample));
    check({name, " busy_first"},   64'(o.busy_first), 64'(exp_strobe - NF - 1));
    check({name, " busy_count"},   64'(o.busy_count), 64'(NF + 2));
    check({name, " sample_held"},  64'(sample), 64'(exp_sample));
  endtask

  vec_t vecs [5];
  obs_t obs;
  int   ec_all0 [NF];
  int   ec_none [NF];
  logic [NF-1:0][LW-1:0] y_tmp;

  initial begin
    ec_all0 = '{0, 0, 0, 0};
    ec_none = '{NEV, NEV, NEV, NEV};

    vecs[0] = '{"pos_half", {NF{32'h0000_8000}}, '{0, 0, 0, 0}, 16'h0004, 7};
    vecs[1] = '{"neg_half", {NF{32'hFFFF_8000}}, '{0, 0, 0, 0}, 16'hFFFC, 7};
    vecs[2] = '{"staggered", {NF{32'h0001_0000}}, '{0, 3, 5, 9}, 16'h0008, 16};
`ifdef STUDENT_FIR_COLLECTOR_SAT_EN
    vecs[3] = '{"max_lanes", {NF{32'h7FFF_FFFF}}, '{0, 0, 0, 0}, 16'h7FFF, 7};
`else
    vecs[3] = '{"max_lanes", {NF{32'h7FFF_FFFF}}, '{0, 0, 0, 0}, 16'h0000, 7};
`endif
    // 65536 - 32768 + 16384 + 8192 = 57344 -> (57344 + 16384) >> 15 = 2
    vecs[4] = '{"mixed", {32'h0000_2000, 32'h0000_4000, 32'hFFFF_8000, 32'h0001_0000},
                '{2, 0, 1, 2}, 16'h0002, 9};

    rst       = 1'b1;
    fir_valid = '0;
    fir_y     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset sample", 64'(sample), 64'd0);
    check("reset strobe", 64'(valid_strobe), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      run_set(vecs[i].y, vecs[i].ec, 20, obs);
      check_set(vecs[i].name, obs, vecs[i].exp_sample, vecs[i].exp_strobe);
      check({vecs[i].name, " overrun"}, 64'(obs.ovr_count), 64'd0);
    end

    // Lane 0 strobes twice before the others: second value dropped.
    y_tmp = {NF{32'h0000_8000}};
    run_set(y_tmp, '{0, NEV, NEV, NEV}, 2, obs);
    check("ovr first_part strobe", 64'(obs.strobe_count), 64'd0);
    y_tmp[0] = 32'h0001_0000;
    run_set(y_tmp, '{0, 2, 2, 2}, 16, obs);
    check("ovr count", 64'(obs.ovr_count), 64'd1);
    check("ovr cycle", 64'(obs.ovr_cycle), 64'd1);
    check_set("ovr", obs, 16'h0004, 9);

    // Reset while summing: outputs clear at once, no strobe follows.
    y_tmp = {NF{32'h0000_8000}};
    run_set(y_tmp, ec_all0, 4, obs);
    check("abort busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort sample", 64'(sample), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort strobe", 64'(valid_strobe), 64'd0);
    check("abort overrun", 64'(overrun), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_set(y_tmp, ec_none, 12, obs);
    check("abort no_strobe", 64'(obs.strobe_count), 64'd0);
    check("abort no_busy", 64'(obs.busy_count), 64'd0);
    run_set(vecs[0].y, vecs[0].ec, 20, obs);
    check_set("after_abort", obs, 16'h0004, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/student_fir_collector.md
Name: student_fir_collector

Overview:
- Consumer end of the FIR output interface. Receives valid_strobe_out/y_out from NUM_FIR parallel FIR slices, which may finish on different cycles.
- Sums the slices sequentially, then rounds, scales and limits the result to one DATA_SIZE output sample.
- Emits that sample with a one-cycle valid strobe to the downstream audio sink.

Parameters:
- NUM_FIR, 4, number of FIR slices collected (>=1)
- DATA_SIZE, 16, output sample width; each slice delivers DATA_SIZE*2 bits
- OUT_SHIFT, 15, arithmetic right shift after rounding (Q15 coefficients)

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-high reset
- fir_valid_i  input  NUM_FIR  per-slice valid strobe; rising edge = new result
- fir_y_i  input  NUM_FIR*DATA_SIZE*2  packed slice results, two's complement; lane k at [k*2*DATA_SIZE +: 2*DATA_SIZE]
- sample_o  output  DATA_SIZE  collected sample, two's complement
- valid_strobe_o  output  1  one-cycle pulse, sample_o valid
- busy_o  output  1  high in SUM, ROUND, OUT
- overrun_o  output  1  one-cycle pulse, a slice result was dropped

Behaviour:
- One clock, asynchronous active-high reset.
- Reset values: sample_o=0, valid_strobe_o=0, busy_o=0, overrun_o=0; all pending bits, capture registers and accumulator cleared; state IDLE.
- Per-lane rising-edge detect on fir_valid_i; the previous-value register resets to 0.
- On an edge on lane k with pending[k]=0: capture fir_y_i lane k and set pending[k].
- On an edge on lane k with pending[k]=1: drop the new value, keep the old one, and pulse overrun_o on the next cycle.
- Accumulator width ACC_W = 2*DATA_SIZE + clog2(NUM_FIR) + 1. Lanes are sign-extended before adding.
- States:
  - IDLE: accumulator cleared. All pending bits set -> SUM, lane index 0.
  - SUM: one lane per cycle, acc += capture[idx]; clear pending[idx]; idx++. After lane NUM_FIR-1 -> ROUND.
  - ROUND: r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, limited to DATA_SIZE (see Optional Feature) and registered into sample_o -> OUT.
  - OUT: valid_strobe_o=1 for exactly this cycle -> IDLE.
- An edge on lane k during SUM:
  - lane k already consumed: captured normally and counts toward the next sample.
  - lane k not yet consumed: overrun.
- Latency: last slice edge in cycle 0 -> valid_strobe_o high in cycle NUM_FIR+3 (cycle 7 for NUM_FIR=4).
- sample_o holds its value until the next ROUND.
- Back-to-back samples are allowed once IDLE is re-entered.
- Reset in any state aborts immediately; no strobe is produced for the partial sample.
- NUM_FIR=1: SUM lasts one cycle.

Optional Feature:
- Macro: STUDENT_FIR_COLLECTOR_SAT_EN
- Defined: r outside [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1] clamps to the nearest bound.
- Undefined: sample_o = r[DATA_SIZE-1:0] (wrap).

Decomposition:
- student_fir_pkg:
  - collector_state_t enum {IDLE, SUM, ROUND, OUT}
  - localparam function for ACC_W
  - saturation function
- Sub-module student_edge_detect, instantiated NUM_FIR times: 1-bit rising-edge detector with async active-high reset.

Test Plan:
- All 4 lanes y=32'h0000_8000 in the same cycle -> sum 131072; sample_o=16'h0004, valid_strobe_o in cycle 7, busy_o high in cycles 2..7.
- All lanes y=32'hFFFF_8000 -> sample_o=16'hFFFC (-4).
- Lane edges at cycles 0, 3, 5, 9, each y=32'h0001_0000 -> sum 262144; valid_strobe_o at cycle 16, sample_o=16'h0008.
- All lanes y=32'h7FFF_FFFF -> with SAT_EN: sample_o=16'h7FFF; without SAT_EN: sample_o=16'h0000.
- Lane 0 strobes twice (values 32'h8000, then 32'h10000) before the other lanes -> overrun_o pulses once; lane 0 contributes 32'h8000.
- Reset asserted during SUM -> all outputs 0 immediately; no valid_strobe_o; the next full lane set produces a correct sample.
